// File: rtl/game_act_pkg.sv
// Shared action encoding for the per-player sequencers: bit indices, timing classes,
// FSM states and the decode helpers used by the channel and the top level.
package game_act_pkg;

  localparam int ACT_BITS      = 10;
  localparam int ACT_MOVE      = 0;
  localparam int ACT_GUARD     = 1;
  localparam int ACT_LPUNCH    = 2;
  localparam int ACT_HPUNCH    = 3;
  localparam int ACT_LKICK     = 4;
  localparam int ACT_HKICK     = 5;
  localparam int ACT_JUMP      = 6;
  localparam int ACT_HIT       = 7;
  localparam int ACT_SKILL     = 8;
  localparam int ACT_SKILL_HIT = 9;

  typedef enum logic [2:0] {CLS_NONE, CLS_SHORT, CLS_LONG, CLS_SKILL, CLS_CONT} cls_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RECOVER} st_e;

  function automatic logic onehot_legal(input logic [ACT_BITS-1:0] code);
    return (code != '0) && ((code & (code - ACT_BITS'(1))) == '0);
  endfunction

  // A hit has no intrinsic class; the caller resolves it from the opponent.
  function automatic cls_e code_to_class(input logic [ACT_BITS-1:0] code);
    cls_e c;
    c = CLS_NONE;
    if (onehot_legal(code)) begin
      if (code[ACT_LPUNCH] || code[ACT_LKICK])
        c = CLS_SHORT;
      else if (code[ACT_HPUNCH] || code[ACT_HKICK])
        c = CLS_LONG;
      else if (code[ACT_SKILL] || code[ACT_SKILL_HIT])
        c = CLS_SKILL;
      else if (code[ACT_MOVE] || code[ACT_GUARD] || code[ACT_JUMP])
        c = CLS_CONT;
    end
    return c;
  endfunction

  function automatic bit timing_ok(input longint len, input longint total, input int cnt_w);
    return (len >= 1) && (total > len) && ((total >> cnt_w) == 0);
  endfunction

endpackage

// File: rtl/action_channel.sv
// One player's animate/recover/idle sequencer; all outputs come from registered state,
// the class output is the only combinational path and feeds the opponent's start logic.
module action_channel
  import game_act_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int SHORT_LEN   = 3_200_000,
  parameter int SHORT_TOTAL = 4_800_000,
  parameter int LONG_LEN    = 4_800_000,
  parameter int LONG_TOTAL  = 6_400_000,
  parameter int SKILL_LEN   = 8_000_000,
  parameter int SKILL_TOTAL = 9_600_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ACT_BITS-1:0] code,
  input  logic                valid,
  input  cls_e                opp_cls,
  input  logic                gait_on,
  output logic [ACT_BITS-1:0] video,
  output logic                busy,
  output logic                done,
  output cls_e                cls
);

  st_e                 state;
  logic [CNT_W-1:0]    cnt;
  logic [ACT_BITS-1:0] code_lat;
  logic [ACT_BITS-1:0] code_q;
  cls_e                cls_lat;
  logic                done_r;

  cls_e             in_cls;
  cls_e             start_cls;
  logic             start_ok;
  logic             preempt;
  logic [CNT_W-1:0] len_cur;
  logic [CNT_W-1:0] total_cur;

  function automatic logic [CNT_W-1:0] len_of(input cls_e c);
    case (c)
      CLS_SHORT: len_of = CNT_W'(SHORT_LEN);
      CLS_LONG:  len_of = CNT_W'(LONG_LEN);
      CLS_SKILL: len_of = CNT_W'(SKILL_LEN);
      default:   len_of = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] total_of(input cls_e c);
    case (c)
      CLS_SHORT: total_of = CNT_W'(SHORT_TOTAL);
      CLS_LONG:  total_of = CNT_W'(LONG_TOTAL);
      CLS_SKILL: total_of = CNT_W'(SKILL_TOTAL);
      default:   total_of = '0;
    endcase
  endfunction

  always_comb begin
    in_cls    = code_to_class(code);
    start_cls = in_cls;
    // A hit borrows the opponent's punch/kick timing; anything else cancels it.
    if (onehot_legal(code) && code[ACT_HIT])
      start_cls = (opp_cls == CLS_SHORT || opp_cls == CLS_LONG) ? opp_cls : CLS_NONE;
    start_ok  = valid && (start_cls == CLS_SHORT || start_cls == CLS_LONG ||
                          start_cls == CLS_SKILL);
    preempt   = valid && onehot_legal(code) && code[ACT_SKILL_HIT] &&
                !code_lat[ACT_SKILL] && !code_lat[ACT_SKILL_HIT];
    len_cur   = len_of(cls_lat);
    total_cur = total_of(cls_lat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      code_lat <= '0;
      cls_lat  <= CLS_NONE;
      code_q   <= '0;
      done_r   <= 1'b0;
    end else begin
      code_q <= code;
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state    <= ST_ACTIVE;
            cnt      <= CNT_W'(1);
            code_lat <= code;
            cls_lat  <= start_cls;
          end
        end
        ST_ACTIVE, ST_RECOVER: begin
          if (preempt) begin
            state    <= ST_ACTIVE;
            cnt      <= CNT_W'(1);
            code_lat <= code;
            cls_lat  <= CLS_SKILL;
          end else if (state == ST_ACTIVE && cnt == len_cur) begin
            state <= ST_RECOVER;
            cnt   <= cnt + CNT_W'(1);
          end else if (state == ST_RECOVER && cnt == total_cur) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            code_lat <= '0;
            cls_lat  <= CLS_NONE;
            done_r   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = done_r;
  assign cls  = busy ? cls_lat : in_cls;

  always_comb begin
    video = '0;
    case (state)
      ST_ACTIVE: video = code_lat;
      ST_IDLE: begin
        if (onehot_legal(code_q)) begin
          video[ACT_MOVE]  = code_q[ACT_MOVE] & gait_on;
          video[ACT_GUARD] = code_q[ACT_GUARD];
          video[ACT_JUMP]  = code_q[ACT_JUMP];
        end
      end
      default: video = '0;
    endcase
  end

endmodule

// File: rtl/action_timer_array.sv
// Per-player action timers: shared gait counter, opponent-class crossbar (p^1)
// and one action_channel per player.
module action_timer_array
  import game_act_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int ACT_W       = 10,
  parameter int CNT_W       = 26,
  parameter int SHORT_LEN   = 3_200_000,
  parameter int SHORT_TOTAL = 4_800_000,
  parameter int LONG_LEN    = 4_800_000,
  parameter int LONG_TOTAL  = 6_400_000,
  parameter int SKILL_LEN   = 8_000_000,
  parameter int SKILL_TOTAL = 9_600_000,
  parameter int MOVE_LEN    = 2_000_000,
  parameter int MOVE_TOTAL  = 4_000_000
) (
  input  logic                         clk,
  input  logic                         RSTn,
  input  logic [NUM_PLAYERS*ACT_W-1:0] act_code,
  input  logic [NUM_PLAYERS-1:0]       act_valid,
  output logic [NUM_PLAYERS*ACT_W-1:0] video_signal,
  output logic [NUM_PLAYERS-1:0]       busy,
  output logic [NUM_PLAYERS-1:0]       done
);

  if (NUM_PLAYERS < 2 || (NUM_PLAYERS % 2) != 0) begin : g_bad_players
    $error("action_timer_array: NUM_PLAYERS must be even and non-zero");
  end
  if (ACT_W != ACT_BITS) begin : g_bad_act_w
    $error("action_timer_array: ACT_W must match the action encoding width");
  end
  if (!timing_ok(SHORT_LEN, SHORT_TOTAL, CNT_W) || !timing_ok(LONG_LEN, LONG_TOTAL, CNT_W) ||
      !timing_ok(SKILL_LEN, SKILL_TOTAL, CNT_W) || !timing_ok(MOVE_LEN, MOVE_TOTAL, CNT_W))
  begin : g_bad_timing
    $error("action_timer_array: need 1 <= LEN < TOTAL < 2**CNT_W for every class");
  end

  logic [CNT_W-1:0] gait_cnt;
  logic             gait_on;
  cls_e             cls [NUM_PLAYERS];

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)
      gait_cnt <= '0;
    else if (gait_cnt == CNT_W'(MOVE_TOTAL - 1))
      gait_cnt <= '0;
    else
      gait_cnt <= gait_cnt + CNT_W'(1);
  end

  assign gait_on = (gait_cnt < CNT_W'(MOVE_LEN));

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    action_channel #(
      .CNT_W      (CNT_W),
      .SHORT_LEN  (SHORT_LEN),
      .SHORT_TOTAL(SHORT_TOTAL),
      .LONG_LEN   (LONG_LEN),
      .LONG_TOTAL (LONG_TOTAL),
      .SKILL_LEN  (SKILL_LEN),
      .SKILL_TOTAL(SKILL_TOTAL)
    ) u_channel (
      .clk    (clk),
      .rst_n  (RSTn),
      .code   (act_code[p*ACT_W +: ACT_W]),
      .valid  (act_valid[p]),
      .opp_cls(cls[p ^ 1]),
      .gait_on(gait_on),
      .video  (video_signal[p*ACT_W +: ACT_W]),
      .busy   (busy[p]),
      .done   (done[p]),
      .cls    (cls[p])
    );
  end

endmodule

// File: tb/tb_action_timer_array.sv
// Directed bench for action_timer_array with short timings (SHORT 4/6, LONG 6/8, SKILL 10/12, MOVE 2/4).
module tb_action_timer_array;

  logic        clk = 1'b0;
  logic        RSTn;
  logic [19:0] act_code;
  logic [1:0]  act_valid;
  logic [19:0] video_signal;
  logic [1:0]  busy;
  logic [1:0]  done;

  int n_cmp = 0;
  int n_bad = 0;
  int g_m;

  always #5 clk = ~clk;

  action_timer_array #(
    .NUM_PLAYERS(2), .ACT_W(10), .CNT_W(26),
    .SHORT_LEN(4), .SHORT_TOTAL(6),
    .LONG_LEN(6),  .LONG_TOTAL(8),
    .SKILL_LEN(10), .SKILL_TOTAL(12),
    .MOVE_LEN(2),  .MOVE_TOTAL(4)
  ) dut (
    .clk         (clk),
    .RSTn        (RSTn),
    .act_code    (act_code),
    .act_valid   (act_valid),
    .video_signal(video_signal),
    .busy        (busy),
    .done        (done)
  );

  // Reference gait phase: counts 0..3 from reset release.
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) g_m <= 0;
    else       g_m <= (g_m == 3) ? 0 : g_m + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input int cyc, input logic [19:0] vid,
                             input logic [1:0] bsy, input logic [1:0] dn);
    check_eq($sformatf("%s c%0d video", tag, cyc), 32'(video_signal), 32'(vid));
    check_eq($sformatf("%s c%0d busy", tag, cyc), 32'(busy), 32'(bsy));
    check_eq($sformatf("%s c%0d done", tag, cyc), 32'(done), 32'(dn));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn      = 1'b0;
    act_code  = '0;
    act_valid = '0;
    repeat (3) @(negedge clk);
    expect_outs("reset", 0, 20'h0, 2'b00, 2'b00);
    RSTn = 1'b1;
    @(negedge clk);

    // Short light punch; a second strobe mid-action must be ignored.
    act_code  = {10'h000, 10'h004};
    act_valid = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      expect_outs("short", i, (i <= 4) ? 20'h00004 : 20'h0, (i <= 6) ? 2'b01 : 2'b00,
                  (i == 7) ? 2'b01 : 2'b00);
      act_valid = (i == 3) ? 2'b01 : 2'b00;
    end

    // P1 heavy punch and P0 hit together: P0 takes P1's LONG timing.
    act_code  = '0;
    @(negedge clk);
    act_code  = {10'h008, 10'h080};
    act_valid = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      act_valid = 2'b00;
      expect_outs("hit_long", i, (i <= 6) ? 20'h02080 : 20'h0, (i <= 8) ? 2'b11 : 2'b00,
                  (i == 9) ? 2'b11 : 2'b00);
    end

    // Heavy kick pre-empted by skill-hit at cycle 3.
    act_code  = '0;
    @(negedge clk);
    act_code  = {10'h000, 10'h020};
    act_valid = 2'b01;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      expect_outs("preempt", i,
                  (i <= 3) ? 20'h00020 : ((i <= 13) ? 20'h00200 : 20'h0),
                  (i <= 15) ? 2'b01 : 2'b00, (i == 16) ? 2'b01 : 2'b00);
      if (i == 3) begin
        act_code  = {10'h000, 10'h200};
        act_valid = 2'b01;
      end else begin
        act_valid = 2'b00;
      end
    end

    // Hit while the opponent only guards: ignored; P1 guard shows as continuous video.
    act_code  = '0;
    @(negedge clk);
    act_code  = {10'h002, 10'h080};
    act_valid = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      act_valid = 2'b00;
      expect_outs("hit_guard", i, 20'h00800, 2'b00, 2'b00);
    end

    // Walk frames follow the gait counter; multi-hot strobe is ignored.
    act_code = '0;
    @(negedge clk);
    act_code = {10'h000, 10'h001};
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      expect_outs("move", i, (g_m < 2) ? 20'h00001 : 20'h0, 2'b00, 2'b00);
    end
    act_code  = {10'h000, 10'h006};
    act_valid = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      expect_outs("multihot", i, 20'h0, 2'b00, 2'b00);
    end
    act_valid = 2'b00;
    act_code  = '0;

    // Reset during RECOVER aborts silently; then full short run plus back-to-back restart.
    @(negedge clk);
    act_code  = {10'h000, 10'h004};
    act_valid = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      act_valid = 2'b00;
      expect_outs("pre_rst", i, (i <= 4) ? 20'h00004 : 20'h0, 2'b01, 2'b00);
    end
    RSTn = 1'b0;
    #1;
    expect_outs("in_rst", 0, 20'h0, 2'b00, 2'b00);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      expect_outs("in_rst", i, 20'h0, 2'b00, 2'b00);
    end
    act_code = '0;
    RSTn     = 1'b1;
    @(negedge clk);
    expect_outs("post_rst", 0, 20'h0, 2'b00, 2'b00);
    act_code  = {10'h000, 10'h010};
    act_valid = 2'b01;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      act_valid = 2'b00;
      expect_outs("post_rst", i, (i <= 4 || i >= 8) ? 20'h00010 : 20'h0,
                  (i <= 6 || i >= 8) ? 2'b01 : 2'b00, (i == 7) ? 2'b01 : 2'b00);
      if (i == 7) act_valid = 2'b01;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
